// File: rtl/addsub_pkg.sv
// Shared types and defaults for the sequential add/subtract unit.
// Latency: none (package only).
// Backpressure: not applicable.
//
// Contents: state_t FSM encoding, default widths, slice_sel helper.
package addsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int WIDTH_DEF   = 64;
   localparam int SLICE_W_DEF = 16;

   // Extract slice k of a default-width word (slice 0 = least significant).
   function automatic logic [SLICE_W_DEF-1:0] slice_sel(input logic [WIDTH_DEF-1:0] v,
                                                        input int unsigned           k);
      return v[k*SLICE_W_DEF +: SLICE_W_DEF];
   endfunction

endpackage

// File: rtl/cla16_slice.sv
// Combinational SLICE_W-bit carry-lookahead adder built from 4-bit groups.
// Latency: 0 cycles (purely combinational).
// Backpressure: not applicable.
//
// Ports: a, b  - addends; cin - carry in; sum - SLICE_W-bit sum; cout - carry out.
// SLICE_W must be a multiple of 4.
module cla16_slice #(
   parameter int SLICE_W = 16
) (
   input  logic [SLICE_W-1:0] a,
   input  logic [SLICE_W-1:0] b,
   input  logic               cin,
   output logic [SLICE_W-1:0] sum,
   output logic               cout
);

   localparam int NGRP = SLICE_W / 4;

   logic [SLICE_W-1:0] p;
   logic [SLICE_W-1:0] g;
   logic [SLICE_W:0]   c;     // carry into each bit plus the final carry-out
   logic [NGRP-1:0]    gp;
   logic [NGRP-1:0]    gg;
   logic [NGRP:0]      gc;    // carry into each 4-bit group

   always_comb begin
      p = a ^ b;
      g = a & b;

      // Group propagate/generate from flattened 4-bit lookahead terms.
      for (int j = 0; j < NGRP; j++) begin
         gp[j] = &p[j*4 +: 4];
         gg[j] = g[j*4+3]
               | (p[j*4+3] & g[j*4+2])
               | (p[j*4+3] & p[j*4+2] & g[j*4+1])
               | (p[j*4+3] & p[j*4+2] & p[j*4+1] & g[j*4]);
      end

      gc[0] = cin;
      for (int j = 0; j < NGRP; j++) begin
         gc[j+1] = gg[j] | (gp[j] & gc[j]);
      end

      // Bit carries inside each group start from that group's lookahead carry.
      c = '0;
      for (int j = 0; j < NGRP; j++) begin
         c[j*4] = gc[j];
         for (int i = 0; i < 3; i++) begin
            c[j*4+i+1] = g[j*4+i] | (p[j*4+i] & c[j*4+i]);
         end
      end
      c[SLICE_W] = gc[NGRP];

      sum  = p ^ c[SLICE_W-1:0];
      cout = c[SLICE_W];
   end

endmodule

// File: rtl/seq_addsub64.sv
// Multi-cycle WIDTH-bit add/subtract, one SLICE_W-bit lookahead slice per clock, LSB slice first.
// Latency: out_valid rises NSLICE cycles after the accepting edge; one op per NSLICE+2 cycles.
// Backpressure: result/flags held in DONE until out_ready; in_ready low outside IDLE.
//
// Ports: clk, rst_n (async active-low); in_valid/in_ready, a, b, op_sub request side;
//        out_valid/out_ready, result, carry_out (1 = no borrow on subtract), overflow result side.
// Optional: define ZERO_FLAG_EN to add output 'zero' (result == 0, valid with out_valid).
module seq_addsub64
   import addsub_pkg::*;
#(
   parameter int WIDTH   = WIDTH_DEF,
   parameter int SLICE_W = SLICE_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             op_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow
`ifdef ZERO_FLAG_EN
   ,
   output logic             zero
`endif
);

   localparam int NSLICE = WIDTH / SLICE_W;
   localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

   state_t             state_q,  state_d;
   logic [WIDTH-1:0]   a_q,      a_d;
   logic [WIDTH-1:0]   b_q,      b_d;       // already inverted for subtract
   logic [CNT_W-1:0]   cnt_q,    cnt_d;
   logic               carry_q,  carry_d;   // carry between slices; seeded with op_sub
   logic [WIDTH-1:0]   result_q, result_d;
   logic               cout_q,   cout_d;
   logic               ovf_q,    ovf_d;
`ifdef ZERO_FLAG_EN
   logic               zero_q,   zero_d;
`endif

   logic [SLICE_W-1:0] slice_a;
   logic [SLICE_W-1:0] slice_b;
   logic [SLICE_W-1:0] slice_sum;
   logic               slice_cout;

   assign slice_a = a_q[cnt_q*SLICE_W +: SLICE_W];
   assign slice_b = b_q[cnt_q*SLICE_W +: SLICE_W];

   cla16_slice #(
      .SLICE_W (SLICE_W)
   ) u_slice (
      .a    (slice_a),
      .b    (slice_b),
      .cin  (carry_q),
      .sum  (slice_sum),
      .cout (slice_cout)
   );

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      cnt_d     = cnt_q;
      carry_d   = carry_q;
      result_d  = result_q;
      cout_d    = cout_q;
      ovf_d     = ovf_q;
`ifdef ZERO_FLAG_EN
      zero_d    = zero_q;
`endif
      in_ready  = 1'b0;
      out_valid = 1'b0;

      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               a_d     = a;
               b_d     = op_sub ? ~b : b;
               carry_d = op_sub;            // +1 completes the two's complement of b
               cnt_d   = '0;
`ifdef ZERO_FLAG_EN
               zero_d  = 1'b1;
`endif
               state_d = CALC;
            end
         end
         CALC: begin
            result_d[cnt_q*SLICE_W +: SLICE_W] = slice_sum;
            carry_d = slice_cout;
            cnt_d   = cnt_q + 1'b1;
`ifdef ZERO_FLAG_EN
            zero_d  = zero_q & (slice_sum == '0);
`endif
            if (cnt_q == LAST) begin
               cout_d  = slice_cout;
               // Signed overflow: operands agree in sign but the sum does not.
               ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                         (slice_sum[SLICE_W-1] != a_q[WIDTH-1]);
               state_d = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         cnt_q    <= '0;
         carry_q  <= 1'b0;
         result_q <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
`ifdef ZERO_FLAG_EN
         zero_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         cnt_q    <= cnt_d;
         carry_q  <= carry_d;
         result_q <= result_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
`ifdef ZERO_FLAG_EN
         zero_q   <= zero_d;
`endif
      end
   end

   assign result    = result_q;
   assign carry_out = cout_q;
   assign overflow  = ovf_q;
`ifdef ZERO_FLAG_EN
   assign zero      = zero_q;
`endif

endmodule

// File: tb/tb_seq_addsub64.sv
// Self-checking bench for seq_addsub64 using an expected-result queue.
// Latency: checks out_valid arrives 4 cycles after acceptance.
// Backpressure: exercises out_ready held low in DONE and out_ready held high from IDLE.
module tb_seq_addsub64;

   typedef struct packed {
      logic [63:0] res;
      logic        cout;
      logic        ovf;
      logic        zero;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] a;
   logic [63:0] b;
   logic        op_sub;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] result;
   logic        carry_out;
   logic        overflow;
`ifdef ZERO_FLAG_EN
   logic        zero;
`endif

   int   n_chk;
   int   n_fail;
   bit   rdy_always;
   exp_t sb[$];

   seq_addsub64 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op_sub    (op_sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .carry_out (carry_out),
      .overflow  (overflow)
`ifdef ZERO_FLAG_EN
      ,
      .zero      (zero)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [63:0] ia, input logic [63:0] ib, input logic isub);
      logic [63:0] bb;
      logic [64:0] s;
      exp_t        e;
      bb     = isub ? ~ib : ib;
      s      = {1'b0, ia} + {1'b0, bb} + 65'(isub);
      e.res  = s[63:0];
      e.cout = s[64];
      e.ovf  = (ia[63] == bb[63]) && (s[63] != ia[63]);
      e.zero = (s[63:0] == 64'd0);
      return e;
   endfunction

   task automatic compare_out(input string pfx, input exp_t e);
      check({pfx, "_result"},    result,    e.res);
      check({pfx, "_carry_out"}, carry_out, e.cout);
      check({pfx, "_overflow"},  overflow,  e.ovf);
`ifdef ZERO_FLAG_EN
      check({pfx, "_zero"},      zero,      e.zero);
`endif
   endtask

   // One full transaction; hold = cycles of out_ready low in DONE,
   // keep_valid = leave in_valid high with scrambled operands during CALC/DONE.
   task automatic do_op(input logic [63:0] ia, input logic [63:0] ib, input logic isub,
                        input int hold, input bit keep_valid);
      exp_t e;
      int   cyc;
      @(negedge clk);
      a        = ia;
      b        = ib;
      op_sub   = isub;
      in_valid = 1'b1;
      check("in_ready_idle", in_ready, 1'b1);
      sb.push_back(model(ia, ib, isub));
      @(posedge clk);
      #1;
      if (keep_valid) begin
         a      = ~ia;
         b      = ia ^ ib;
         op_sub = ~isub;
      end else begin
         in_valid = 1'b0;
      end
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
         if (!out_valid && cyc > 1) check("in_ready_calc", in_ready, 1'b0);
      end while (!out_valid && cyc < 20);
      check("out_valid_seen", out_valid, 1'b1);
      check("latency", 64'(cyc - 1), 64'd4);
      check("in_ready_done", in_ready, 1'b0);
      in_valid = 1'b0;
      e = sb.pop_front();
      for (int i = 0; i < hold; i++) begin
         compare_out("hold", e);
         check("hold_out_valid", out_valid, 1'b1);
         check("hold_in_ready", in_ready, 1'b0);
         @(negedge clk);
      end
      compare_out("op", e);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      if (!rdy_always) out_ready = 1'b0;
      @(negedge clk);
      check("out_valid_after", out_valid, 1'b0);
      check("in_ready_after", in_ready, 1'b1);
   endtask

   initial begin
      n_chk      = 0;
      n_fail     = 0;
      rdy_always = 1'b0;
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      out_ready  = 1'b0;
      a          = '0;
      b          = '0;
      op_sub     = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_in_ready",  in_ready,  1'b1);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_result",    result,    64'd0);
      check("rst_carry_out", carry_out, 1'b0);
      check("rst_overflow",  overflow,  1'b0);
`ifdef ZERO_FLAG_EN
      check("rst_zero",      zero,      1'b0);
`endif
      rst_n = 1'b1;

      // Directed vectors
      do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 0, 1'b0);
      check("wrap_result_const", result, 64'd0);
      do_op(64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 0, 1'b0);
      check("slice_carry_const", result, 64'h0000_0000_0001_0000);
      do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 0, 1'b0);
      check("ovf_const", overflow, 1'b1);
      do_op(64'd5, 64'd7, 1'b1, 0, 1'b0);
      check("borrow_const", result, 64'hFFFF_FFFF_FFFF_FFFE);
      do_op(64'd7, 64'd5, 1'b1, 0, 1'b0);
      check("sub_const", result, 64'd2);
      do_op(64'hDEAD_BEEF_0123_4567, 64'd0, 1'b1, 0, 1'b0);
      check("sub_zero_cout", carry_out, 1'b1);
      do_op(64'h8000_0000_0000_0000, 64'd1, 1'b1, 0, 1'b0);

      // Backpressure with in_valid held high through CALC/DONE
      do_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 3, 1'b1);

      // out_ready held high while idle and calculating
      rdy_always = 1'b1;
      out_ready  = 1'b1;
      do_op(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 0, 1'b0);
      rdy_always = 1'b0;
      out_ready  = 1'b0;

      // Random operands
      for (int i = 0; i < 6; i++) begin
         do_op({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
               $urandom_range(0, 2), 1'b0);
      end

      // Reset during the second CALC cycle
      @(negedge clk);
      a        = 64'h0000_0000_0000_1234;
      b        = 64'h0000_0000_0000_0001;
      op_sub   = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("abort_out_valid", out_valid, 1'b0);
      check("abort_result",    result,    64'd0);
      check("abort_in_ready",  in_ready,  1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      do_op(64'h0000_0000_0001_FFFF, 64'h0000_0000_0000_0001, 1'b0, 1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
